// File: rtl/tribonacci_checker.sv
// rtl/tribonacci_checker.sv - checks an incoming stream against the tribonacci recurrence
// FILL compares seeds, CHECK compares against the three-term window sum, HALT freezes everything.
module tribonacci_checker #(
  parameter logic [31:0] SEED0     = 32'd0,
  parameter logic [31:0] SEED1     = 32'd0,
  parameter logic [31:0] SEED2     = 32'd1,
  parameter logic [15:0] MAX_TERMS = 16'd150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        s_valid,
  input  logic [31:0] s,
  output logic [15:0] term_cnt,
  output logic        err,
  output logic [15:0] err_idx,
  output logic        ovf,
  output logic        done
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CHECK = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] t1_q, t2_q, t3_q;
  logic [31:0] t1_d, t2_d, t3_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] err_idx_q, err_idx_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic        accept;
  logic [33:0] sum;
  logic [31:0] seed_exp;
  logic [31:0] expected;
  logic        mismatch;
  logic        last;

  // clr wins over a same-cycle valid term, so it also blocks acceptance
  assign accept   = s_valid && !clr && (state_q != HALT);
  assign sum      = {2'b00, t1_q} + {2'b00, t2_q} + {2'b00, t3_q};
  assign expected = (state_q == FILL) ? seed_exp : sum[31:0];
  assign mismatch = (s != expected);
  assign last     = (cnt_q == (MAX_TERMS - 16'd1));

  always_comb begin
    seed_exp = SEED2;
    case (cnt_q[1:0])
      2'd0:    seed_exp = SEED0;
      2'd1:    seed_exp = SEED1;
      default: seed_exp = SEED2;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else if (clr) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (mismatch || last) begin
            state_d = HALT;
          end else if (cnt_q == 16'd2) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept && (mismatch || last)) begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    t1_d      = t1_q;
    t2_d      = t2_q;
    t3_d      = t3_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    if (accept) begin
      t1_d  = t2_q;
      t2_d  = t3_q;
      t3_d  = s;
      cnt_d = cnt_q + 16'd1;
      if (mismatch) begin
        err_d     = 1'b1;
        err_idx_d = cnt_q;
      end else if (last) begin
        done_d = 1'b1;
      end
      // overflow is informational only; the low 32 bits are still compared
      if ((state_q == CHECK) && (sum[33:32] != 2'b00)) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_q      <= '0;
      t2_q      <= '0;
      t3_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (clr) begin
      t1_q      <= '0;
      t2_q      <= '0;
      t3_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      t1_q      <= t1_d;
      t2_q      <= t2_d;
      t3_q      <= t3_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign term_cnt = cnt_q;
  assign err      = err_q;
  assign err_idx  = err_idx_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tribonacci_checker.sv
// tb/tb_tribonacci_checker.sv - directed self-checking bench for tribonacci_checker
module tb_tribonacci_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        s_valid_a = 1'b0;
  logic [31:0] s_a = '0;
  logic [15:0] term_cnt_a, err_idx_a;
  logic        err_a, ovf_a, done_a;
  logic        s_valid_b = 1'b0;
  logic [31:0] s_b = '0;
  logic [15:0] term_cnt_b, err_idx_b;
  logic        err_b, ovf_b, done_b;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] BIG = 32'h8000_0000;
  logic [31:0] hand [0:9] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd4, 32'd7, 32'd13, 32'd24, 32'd44};

  always #5 clk = ~clk;

  tribonacci_checker u_dut (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid_a), .s(s_a),
    .term_cnt(term_cnt_a), .err(err_a), .err_idx(err_idx_a), .ovf(ovf_a), .done(done_a)
  );

  tribonacci_checker #(.SEED0(BIG), .SEED1(BIG), .SEED2(BIG), .MAX_TERMS(16'd5)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid_b), .s(s_b),
    .term_cnt(term_cnt_b), .err(err_b), .err_idx(err_idx_b), .ovf(ovf_b), .done(done_b)
  );

  function automatic logic [31:0] trib(input int n);
    logic [31:0] a, b, c, nx;
    a = 32'd0; b = 32'd0; c = 32'd1;
    if (n == 0) return a;
    if (n == 1) return b;
    if (n == 2) return c;
    for (int k = 3; k <= n; k++) begin
      nx = a + b + c;
      a = b; b = c; c = nx;
    end
    return c;
  endfunction

  function automatic logic ovf_model(input int n);
    logic [31:0] a, b, c;
    logic [33:0] sm;
    logic        f;
    a = 32'd0; b = 32'd0; c = 32'd1; f = 1'b0;
    for (int k = 3; k < n; k++) begin
      sm = {2'b00, a} + {2'b00, b} + {2'b00, c};
      if (sm[33:32] != 2'b00) f = 1'b1;
      a = b; b = c; c = sm[31:0];
    end
    return f;
  endfunction

  task automatic step_a(input logic v, input logic [31:0] d);
    s_valid_a = v; s_a = d;
    @(negedge clk);
    s_valid_a = 1'b0;
  endtask

  task automatic step_b(input logic v, input logic [31:0] d);
    s_valid_b = v; s_b = d;
    @(negedge clk);
    s_valid_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({term_cnt_a, err_a, err_idx_a, ovf_a, done_a} !== 35'd0) begin
      n_fail++; $display("FAIL reset_a got %h want 0", {term_cnt_a, err_a, err_idx_a, ovf_a, done_a});
    end
    n_cmp++;
    if ({term_cnt_b, err_b, err_idx_b, ovf_b, done_b} !== 35'd0) begin
      n_fail++; $display("FAIL reset_b got %h want 0", {term_cnt_b, err_b, err_idx_b, ovf_b, done_b});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_stream();
    do_reset();
    for (int i = 0; i < 149; i++) begin
      step_a(1'b1, trib(i));
      if (i == 20) begin
        n_cmp++;
        if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL full_early_ovf got %b want 0", ovf_a); end
      end
    end
    n_cmp++;
    if (done_a !== 1'b0 || term_cnt_a !== 16'd149) begin
      n_fail++; $display("FAIL full_before_last got done=%b cnt=%0d want done=0 cnt=149", done_a, term_cnt_a);
    end
    step_a(1'b1, trib(149));
    n_cmp++;
    if (done_a !== 1'b1 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL full_done got done=%b err=%b want done=1 err=0", done_a, err_a);
    end
    n_cmp++;
    if (term_cnt_a !== 16'd150) begin n_fail++; $display("FAIL full_cnt got %0d want 150", term_cnt_a); end
    n_cmp++;
    if (ovf_a !== ovf_model(150)) begin n_fail++; $display("FAIL full_ovf got %b want %b", ovf_a, ovf_model(150)); end
    step_a(1'b1, 32'hDEAD_BEEF);
    n_cmp++;
    if (term_cnt_a !== 16'd150 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL full_halt got cnt=%0d err=%b want cnt=150 err=0", term_cnt_a, err_a);
    end
  endtask

  task automatic test_mismatch_mid();
    do_reset();
    for (int i = 0; i < 7; i++) step_a(1'b1, hand[i]);
    n_cmp++;
    if (err_a !== 1'b0 || term_cnt_a !== 16'd7) begin
      n_fail++; $display("FAIL mid_pre got err=%b cnt=%0d want err=0 cnt=7", err_a, term_cnt_a);
    end
    step_a(1'b1, 32'd14);
    n_cmp++;
    if (err_a !== 1'b1 || err_idx_a !== 16'd7 || term_cnt_a !== 16'd8) begin
      n_fail++; $display("FAIL mid_err got err=%b idx=%0d cnt=%0d want 1/7/8", err_a, err_idx_a, term_cnt_a);
    end
    for (int i = 8; i < 10; i++) step_a(1'b1, hand[i]);
    n_cmp++;
    if (term_cnt_a !== 16'd8 || err_idx_a !== 16'd7 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL mid_halt got cnt=%0d idx=%0d done=%b want 8/7/0", term_cnt_a, err_idx_a, done_a);
    end
  endtask

  task automatic test_seed_mismatch();
    do_reset();
    step_a(1'b1, 32'd0);
    step_a(1'b1, 32'd5);
    step_a(1'b1, 32'd1);
    n_cmp++;
    if (err_a !== 1'b1 || err_idx_a !== 16'd1 || term_cnt_a !== 16'd2) begin
      n_fail++; $display("FAIL seed_err got err=%b idx=%0d cnt=%0d want 1/1/2", err_a, err_idx_a, term_cnt_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) step_b(1'b1, BIG);
    n_cmp++;
    if (ovf_b !== 1'b0 || err_b !== 1'b0) begin
      n_fail++; $display("FAIL wrap_fill got ovf=%b err=%b want 0/0", ovf_b, err_b);
    end
    step_b(1'b1, BIG);
    n_cmp++;
    if (ovf_b !== 1'b1 || err_b !== 1'b0 || term_cnt_b !== 16'd4 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL wrap_term3 got ovf=%b err=%b cnt=%0d done=%b want 1/0/4/0", ovf_b, err_b, term_cnt_b, done_b);
    end
    step_b(1'b1, BIG);
    n_cmp++;
    if (done_b !== 1'b1 || err_b !== 1'b0 || term_cnt_b !== 16'd5) begin
      n_fail++; $display("FAIL wrap_done got done=%b err=%b cnt=%0d want 1/0/5", done_b, err_b, term_cnt_b);
    end
  endtask

  task automatic test_last_mismatch();
    do_reset();
    for (int i = 0; i < 4; i++) step_b(1'b1, BIG);
    step_b(1'b1, 32'd0);
    n_cmp++;
    if (err_b !== 1'b1 || err_idx_b !== 16'd4 || done_b !== 1'b0) begin
      n_fail++; $display("FAIL last_err got err=%b idx=%0d done=%b want 1/4/0", err_b, err_idx_b, done_b);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      step_a(1'b1, trib(i));
      step_a(1'b0, 32'hFFFF_FFFF);
      if (i == 75) begin
        n_cmp++;
        if (term_cnt_a !== 16'd76) begin n_fail++; $display("FAIL gap_cnt got %0d want 76", term_cnt_a); end
      end
    end
    n_cmp++;
    if (done_a !== 1'b1 || err_a !== 1'b0 || term_cnt_a !== 16'd150 || ovf_a !== ovf_model(150)) begin
      n_fail++; $display("FAIL gap_end got done=%b err=%b cnt=%0d ovf=%b want 1/0/150/%b",
                         done_a, err_a, term_cnt_a, ovf_a, ovf_model(150));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step_a(1'b1, trib(i));
    step_a(1'b1, 32'd99);
    n_cmp++;
    if (term_cnt_a !== 16'd7 || err_a !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got cnt=%0d err=%b want 7/1", term_cnt_a, err_a);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({term_cnt_a, err_a, err_idx_a, ovf_a, done_a} !== 35'd0) begin
      n_fail++; $display("FAIL arst_async got %h want 0", {term_cnt_a, err_a, err_idx_a, ovf_a, done_a});
    end
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 150; i++) step_a(1'b1, trib(i));
    n_cmp++;
    if (done_a !== 1'b1 || err_a !== 1'b0 || term_cnt_a !== 16'd150) begin
      n_fail++; $display("FAIL arst_fresh got done=%b err=%b cnt=%0d want 1/0/150", done_a, err_a, term_cnt_a);
    end
  endtask

  task automatic test_clr_with_valid();
    do_reset();
    step_a(1'b1, 32'd0);
    step_a(1'b1, 32'd5);
    clr = 1'b1;
    step_a(1'b1, 32'd77);
    clr = 1'b0;
    n_cmp++;
    if (term_cnt_a !== 16'd0 || err_a !== 1'b0 || err_idx_a !== 16'd0) begin
      n_fail++; $display("FAIL clr_drop got cnt=%0d err=%b idx=%0d want 0/0/0", term_cnt_a, err_a, err_idx_a);
    end
    step_a(1'b1, 32'd0);
    n_cmp++;
    if (term_cnt_a !== 16'd1 || err_a !== 1'b0) begin
      n_fail++; $display("FAIL clr_restart got cnt=%0d err=%b want 1/0", term_cnt_a, err_a);
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_mismatch_mid();
    test_seed_mismatch();
    test_wrap();
    test_last_mismatch();
    test_gaps();
    test_async_reset();
    test_clr_with_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
